// File: rtl/regfile_write_arbiter_if.sv
// Bus bundle for the register-file write-port arbiter: WB request, aux handshake,
// the arbitrated write port, hazard/scoreboard outputs and optional forwarding taps.
interface regfile_write_arbiter_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 4,
   parameter int CNT_W  = 3
);
   logic              wbEn;
   logic [ADDR_W-1:0] wbDest;
   logic [DATA_W-1:0] wbResult;
   logic              auxValid;
   logic              auxReady;
   logic [ADDR_W-1:0] auxDest;
   logic [DATA_W-1:0] auxResult;
   logic              writeBackEn;
   logic [ADDR_W-1:0] destWB;
   logic [DATA_W-1:0] resultWB;
   logic [ADDR_W-1:0] src1;
   logic [ADDR_W-1:0] src2;
   logic              hazard;
   logic              stallReq;
   logic [CNT_W-1:0]  pendCount;
   logic              fwdValid1;
   logic              fwdValid2;
   logic [DATA_W-1:0] fwdData1;
   logic [DATA_W-1:0] fwdData2;

   modport master (
      output wbEn, wbDest, wbResult, auxValid, auxDest, auxResult, src1, src2,
      input  auxReady, writeBackEn, destWB, resultWB, hazard, stallReq, pendCount,
             fwdValid1, fwdValid2, fwdData1, fwdData2
   );

   modport slave (
      input  wbEn, wbDest, wbResult, auxValid, auxDest, auxResult, src1, src2,
      output auxReady, writeBackEn, destWB, resultWB, hazard, stallReq, pendCount,
             fwdValid1, fwdValid2, fwdData1, fwdData2
   );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Arbitrates the register file's single write port between the WB stage and an aux unit
// buffered in an in-order FIFO. Optional forwarding taps: define REGFILE_ARB_FORWARD_EN.
module regfile_write_arbiter #(
   parameter int DATA_W       = 32,
   parameter int ADDR_W       = 4,
   parameter int FIFO_DEPTH   = 4,
   parameter int STARVE_LIMIT = 8
) (
   input logic clk,
   input logic rst,
   regfile_write_arbiter_if.slave bus
);
   localparam int IDX_W  = $clog2(FIFO_DEPTH);
   localparam int PTR_W  = IDX_W + 1;
   localparam int SCNT_W = $clog2(STARVE_LIMIT + 1);
   localparam logic [ADDR_W-1:0] PC_IDX    = ADDR_W'(4'd15);
   localparam logic [SCNT_W-1:0] STARVE_LV = SCNT_W'(STARVE_LIMIT);

   logic [ADDR_W-1:0]     dest_r [FIFO_DEPTH];
   logic [DATA_W-1:0]     data_r [FIFO_DEPTH];
   logic [FIFO_DEPTH-1:0] live_r;
   logic [PTR_W-1:0]      wr_ptr_r;
   logic [PTR_W-1:0]      rd_ptr_r;
   logic [SCNT_W-1:0]     starve_r;
   logic                  stall_r;
   logic                  wbe_r;
   logic [ADDR_W-1:0]     dest_wb_r;
   logic [DATA_W-1:0]     result_wb_r;

   logic [IDX_W-1:0]      rd_idx_s;
   logic [IDX_W-1:0]      wr_idx_s;
   logic                  empty_s;
   logic                  full_s;
   logic                  push_s;
   logic                  pop_s;
   logic                  wb_grant_s;
   logic                  head_live_s;
   logic [SCNT_W-1:0]     starve_nxt_s;
   logic [FIFO_DEPTH-1:0] live_nxt_s;
   logic                  hit1_s;
   logic                  hit2_s;
   logic [DATA_W-1:0]     data1_s;
   logic [DATA_W-1:0]     data2_s;

   function automatic logic [IDX_W-1:0] age_idx(input logic [IDX_W-1:0] base,
                                                 input int unsigned       off);
      return base + off[IDX_W-1:0];
   endfunction

   assign rd_idx_s    = rd_ptr_r[IDX_W-1:0];
   assign wr_idx_s    = wr_ptr_r[IDX_W-1:0];
   assign empty_s     = (wr_ptr_r == rd_ptr_r);
   assign full_s      = (wr_idx_s == rd_idx_s) && (wr_ptr_r[IDX_W] != rd_ptr_r[IDX_W]);
   assign push_s      = bus.auxValid && !full_s && (bus.auxDest != PC_IDX);
   assign wb_grant_s  = bus.wbEn && (bus.wbDest != PC_IDX);
   assign pop_s       = !bus.wbEn && !empty_s;
   // live bits are cleared on pop, so an empty slot never reads as live
   assign head_live_s = live_r[rd_idx_s];

   // Starvation counter: counts cycles a live head loses to WB, saturating at the limit
   always_comb begin
      starve_nxt_s = starve_r;
      if (pop_s || empty_s) begin
         starve_nxt_s = '0;
      end else if (head_live_s && wb_grant_s && (starve_r < STARVE_LV)) begin
         starve_nxt_s = starve_r + SCNT_W'(1'b1);
      end else begin
         starve_nxt_s = starve_r;
      end
   end

   // Next live vector: WB kill on matching dest, then pop clears head, then push sets tail
   always_comb begin
      live_nxt_s = live_r;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
         live_nxt_s[i] = live_r[i] & ~(wb_grant_s && (dest_r[i] == bus.wbDest));
      end
      if (pop_s) begin
         live_nxt_s[rd_idx_s] = 1'b0;
      end else begin
         live_nxt_s[rd_idx_s] = live_nxt_s[rd_idx_s];
      end
      if (push_s) begin
         live_nxt_s[wr_idx_s] = 1'b1;
      end else begin
         live_nxt_s[wr_idx_s] = live_nxt_s[wr_idx_s];
      end
   end

   // Source match scan from oldest to youngest so the last hit is the youngest entry
   always_comb begin
      hit1_s  = 1'b0;
      hit2_s  = 1'b0;
      data1_s = '0;
      data2_s = '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
         logic [IDX_W-1:0] k;
         logic             m1;
         logic             m2;
         k  = age_idx(rd_idx_s, i);
         m1 = live_r[k] && (dest_r[k] == bus.src1) && (bus.src1 != PC_IDX);
         m2 = live_r[k] && (dest_r[k] == bus.src2) && (bus.src2 != PC_IDX);
         hit1_s  = hit1_s | m1;
         hit2_s  = hit2_s | m2;
         data1_s = m1 ? data_r[k] : data1_s;
         data2_s = m2 ? data_r[k] : data2_s;
      end
   end

   // FIFO storage, pointers, starvation state and the registered write port
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            dest_r[i] <= '0;
            data_r[i] <= '0;
         end
         live_r      <= '0;
         wr_ptr_r    <= '0;
         rd_ptr_r    <= '0;
         starve_r    <= '0;
         stall_r     <= 1'b0;
         wbe_r       <= 1'b0;
         dest_wb_r   <= '0;
         result_wb_r <= '0;
      end else begin
         if (wb_grant_s) begin
            wbe_r       <= 1'b1;
            dest_wb_r   <= bus.wbDest;
            result_wb_r <= bus.wbResult;
         end else if (pop_s && head_live_s) begin
            wbe_r       <= 1'b1;
            dest_wb_r   <= dest_r[rd_idx_s];
            result_wb_r <= data_r[rd_idx_s];
         end else begin
            wbe_r <= 1'b0;
         end

         if (push_s) begin
            dest_r[wr_idx_s] <= bus.auxDest;
            data_r[wr_idx_s] <= bus.auxResult;
            wr_ptr_r         <= wr_ptr_r + PTR_W'(1'b1);
         end else begin
            wr_ptr_r <= wr_ptr_r;
         end

         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_W'(1'b1);
         end else begin
            rd_ptr_r <= rd_ptr_r;
         end

         live_r   <= live_nxt_s;
         starve_r <= starve_nxt_s;
         stall_r  <= (starve_nxt_s >= STARVE_LV);
      end
   end

   assign bus.auxReady    = !full_s;
   assign bus.pendCount   = wr_ptr_r - rd_ptr_r;
   assign bus.writeBackEn = wbe_r;
   assign bus.destWB      = dest_wb_r;
   assign bus.resultWB    = result_wb_r;
   assign bus.stallReq    = stall_r;

`ifdef REGFILE_ARB_FORWARD_EN
   // every live match can be forwarded, so no source is left to raise a hazard
   assign bus.fwdValid1 = hit1_s;
   assign bus.fwdValid2 = hit2_s;
   assign bus.fwdData1  = data1_s;
   assign bus.fwdData2  = data2_s;
   assign bus.hazard    = (hit1_s & ~hit1_s) | (hit2_s & ~hit2_s);
`else
   assign bus.fwdValid1 = 1'b0;
   assign bus.fwdValid2 = 1'b0;
   assign bus.fwdData1  = '0;
   assign bus.fwdData2  = '0;
   assign bus.hazard    = hit1_s | hit2_s;
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Self-checking bench for regfile_write_arbiter: queue-based reference model compared every
// cycle, plus hand-computed directed expectations. Honours REGFILE_ARB_FORWARD_EN.
module tb_regfile_write_arbiter;
   localparam int DATA_W       = 32;
   localparam int ADDR_W       = 4;
   localparam int FIFO_DEPTH   = 4;
   localparam int STARVE_LIMIT = 8;
   localparam int CNT_W        = $clog2(FIFO_DEPTH) + 1;

   typedef struct {
      logic [ADDR_W-1:0] dest;
      logic [DATA_W-1:0] data;
      bit                live;
   } ent_t;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   regfile_write_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();

   regfile_write_arbiter #(
      .DATA_W(DATA_W), .ADDR_W(ADDR_W), .FIFO_DEPTH(FIFO_DEPTH), .STARVE_LIMIT(STARVE_LIMIT)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   ent_t              q[$];
   bit                m_wbe = 1'b0;
   logic [ADDR_W-1:0] m_dest = '0;
   logic [DATA_W-1:0] m_res = '0;
   int                m_lose = 0;
   bit                started = 1'b0;

   task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: a queue of pending aux writes and the rules of the write port
   always @(posedge clk) begin
      int   sz;
      bit   grant;
      bit   popq;
      bit   head_live;
      ent_t h;
      started = 1'b1;
      sz = q.size();
      if (rst) begin
         q.delete();
         m_wbe  = 1'b0;
         m_dest = '0;
         m_res  = '0;
         m_lose = 0;
      end else begin
         grant     = bus.wbEn && (bus.wbDest != 4'd15);
         popq      = !bus.wbEn && (sz > 0);
         head_live = (sz > 0) && q[0].live;
         if (popq || sz == 0) m_lose = 0;
         else if (head_live && grant) m_lose = m_lose + 1;
         if (grant) begin
            m_wbe  = 1'b1;
            m_dest = bus.wbDest;
            m_res  = bus.wbResult;
            foreach (q[i]) if (q[i].dest == bus.wbDest) q[i].live = 1'b0;
         end else if (popq) begin
            h = q.pop_front();
            m_wbe = h.live;
            if (h.live) begin
               m_dest = h.dest;
               m_res  = h.data;
            end
         end else begin
            m_wbe = 1'b0;
         end
         if (bus.auxValid && sz < FIFO_DEPTH && bus.auxDest != 4'd15)
            q.push_back('{dest: bus.auxDest, data: bus.auxResult, live: 1'b1});
      end
   end

   // Compare process: all outputs against the model, mid-cycle
   always @(negedge clk) begin
      bit                v1;
      bit                v2;
      logic [DATA_W-1:0] f1;
      logic [DATA_W-1:0] f2;
      if (started) begin
         v1 = 1'b0; v2 = 1'b0; f1 = '0; f2 = '0;
         foreach (q[i]) begin
            if (q[i].live && bus.src1 != 4'd15 && q[i].dest == bus.src1) begin
               v1 = 1'b1; f1 = q[i].data;
            end
            if (q[i].live && bus.src2 != 4'd15 && q[i].dest == bus.src2) begin
               v2 = 1'b1; f2 = q[i].data;
            end
         end
         cmp("writeBackEn", 64'(bus.writeBackEn), 64'(m_wbe));
         cmp("destWB", 64'(bus.destWB), 64'(m_dest));
         cmp("resultWB", 64'(bus.resultWB), 64'(m_res));
         cmp("auxReady", 64'(bus.auxReady), 64'(q.size() < FIFO_DEPTH));
         cmp("pendCount", 64'(bus.pendCount), 64'(q.size()));
         cmp("stallReq", 64'(bus.stallReq), 64'(m_lose >= STARVE_LIMIT));
`ifdef REGFILE_ARB_FORWARD_EN
         cmp("hazard", 64'(bus.hazard), 64'(0));
         cmp("fwdValid1", 64'(bus.fwdValid1), 64'(v1));
         cmp("fwdValid2", 64'(bus.fwdValid2), 64'(v2));
         cmp("fwdData1", 64'(bus.fwdData1), 64'(f1));
         cmp("fwdData2", 64'(bus.fwdData2), 64'(f2));
`else
         cmp("hazard", 64'(bus.hazard), 64'(v1 | v2));
         cmp("fwdValid1", 64'(bus.fwdValid1), 64'(0));
         cmp("fwdValid2", 64'(bus.fwdValid2), 64'(0));
         cmp("fwdData1", 64'(bus.fwdData1), 64'(0));
         cmp("fwdData2", 64'(bus.fwdData2), 64'(0));
`endif
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.wbEn = 1'b0; bus.wbDest = '0; bus.wbResult = '0;
      bus.auxValid = 1'b0; bus.auxDest = '0; bus.auxResult = '0;
      bus.src1 = '0; bus.src2 = '0;
   endtask

   initial begin
      rst = 1'b1;
      idle();
      // reset held two cycles while the aux unit tries to push
      bus.auxValid = 1'b1; bus.auxDest = 4'd4; bus.auxResult = 32'h4444;
      repeat (2) step();
      rst = 1'b0;
      bus.auxValid = 1'b0;
      cmp("rst_wbe", 64'(bus.writeBackEn), 64'd0);
      cmp("rst_pend", 64'(bus.pendCount), 64'd0);
      cmp("rst_ready", 64'(bus.auxReady), 64'd1);
      cmp("rst_stall", 64'(bus.stallReq), 64'd0);
      step();
      cmp("rst_noenq", 64'(bus.pendCount), 64'd0);

      // uncontested aux write: visible two edges after the handshake
      bus.auxValid = 1'b1; bus.auxDest = 4'd3; bus.auxResult = 32'hDEAD;
      step();
      bus.auxValid = 1'b0; bus.src1 = 4'd3;
      #1;
      cmp("aux_hazard_n1", 64'(bus.hazard), 64'd1);
      cmp("aux_wbe_n1", 64'(bus.writeBackEn), 64'd0);
      step();
      cmp("aux_wbe_n2", 64'(bus.writeBackEn), 64'd1);
      cmp("aux_dest_n2", 64'(bus.destWB), 64'd3);
      cmp("aux_data_n2", 64'(bus.resultWB), 64'hDEAD);
      cmp("aux_hazard_n2", 64'(bus.hazard), 64'd0);
      bus.src1 = 4'd0;
      step();
      cmp("aux_hold_dest", 64'(bus.destWB), 64'd3);

      // full FIFO and starvation under continuous WB traffic
      bus.wbEn = 1'b1; bus.wbDest = 4'd1; bus.wbResult = 32'h100;
      bus.auxValid = 1'b1;
      for (int k = 0; k < 4; k++) begin
         bus.auxDest = 4'(8 + k); bus.auxResult = 32'h80 + 32'(k);
         step();
      end
      cmp("full_ready", 64'(bus.auxReady), 64'd0);
      cmp("full_pend", 64'(bus.pendCount), 64'd4);
      bus.auxDest = 4'd12; bus.auxResult = 32'hCC;
      step();
      bus.auxValid = 1'b0;
      cmp("full_nopush", 64'(bus.pendCount), 64'd4);
      repeat (3) step();
      cmp("stall_7", 64'(bus.stallReq), 64'd0);
      step();
      cmp("stall_8", 64'(bus.stallReq), 64'd1);
      repeat (2) step();
      cmp("stall_hold", 64'(bus.stallReq), 64'd1);
      bus.wbEn = 1'b0;
      for (int k = 0; k < 4; k++) begin
         step();
         cmp("drain_wbe", 64'(bus.writeBackEn), 64'd1);
         cmp("drain_dest", 64'(bus.destWB), 64'(8 + k));
         cmp("drain_data", 64'(bus.resultWB), 64'(32'h80 + 32'(k)));
         if (k == 0) cmp("drain_stall_clr", 64'(bus.stallReq), 64'd0);
      end
      cmp("drain_pend", 64'(bus.pendCount), 64'd0);

      // kill: younger WB write to the same dest cancels the pending aux entry
      bus.auxValid = 1'b1; bus.auxDest = 4'd5; bus.auxResult = 32'h11;
      step();
      bus.auxValid = 1'b0; bus.src1 = 4'd5;
      bus.wbEn = 1'b1; bus.wbDest = 4'd5; bus.wbResult = 32'h22;
      #1;
      cmp("kill_hazard_pre", 64'(bus.hazard), 64'd1);
      step();
      bus.wbEn = 1'b0;
      cmp("kill_wb_dest", 64'(bus.destWB), 64'd5);
      cmp("kill_wb_data", 64'(bus.resultWB), 64'h22);
      cmp("kill_hazard_post", 64'(bus.hazard), 64'd0);
      cmp("kill_pend", 64'(bus.pendCount), 64'd1);
      step();
      cmp("kill_silent_pop", 64'(bus.writeBackEn), 64'd0);
      cmp("kill_hold_data", 64'(bus.resultWB), 64'h22);
      cmp("kill_pend_0", 64'(bus.pendCount), 64'd0);
      bus.src1 = 4'd0;

      // PC destination from both requesters; WB to PC also blocks the head
      bus.wbEn = 1'b1; bus.wbDest = 4'd15; bus.wbResult = 32'h33;
      bus.auxValid = 1'b1; bus.auxDest = 4'd15; bus.auxResult = 32'h44;
      step();
      cmp("pc_wbe", 64'(bus.writeBackEn), 64'd0);
      cmp("pc_pend", 64'(bus.pendCount), 64'd0);
      bus.auxDest = 4'd6; bus.auxResult = 32'h66;
      step();
      bus.auxValid = 1'b0;
      step();
      cmp("pc_block_wbe", 64'(bus.writeBackEn), 64'd0);
      cmp("pc_block_pend", 64'(bus.pendCount), 64'd1);
      bus.wbEn = 1'b0;
      step();
      cmp("pc_after_dest", 64'(bus.destWB), 64'd6);

      // reset in the middle of pending traffic
      bus.wbEn = 1'b1; bus.wbDest = 4'd2; bus.wbResult = 32'h2;
      bus.auxValid = 1'b1; bus.auxDest = 4'd9; step();
      bus.auxDest = 4'd10; step();
      bus.auxValid = 1'b0; rst = 1'b1; step();
      cmp("midrst_wbe", 64'(bus.writeBackEn), 64'd0);
      cmp("midrst_pend", 64'(bus.pendCount), 64'd0);
      rst = 1'b0; bus.wbEn = 1'b0; step();
      cmp("midrst_nowrite", 64'(bus.writeBackEn), 64'd0);

      // two pending writes to the same dest: youngest data is the forwarding candidate
      bus.wbEn = 1'b1; bus.wbDest = 4'd1; bus.wbResult = 32'h1;
      bus.auxValid = 1'b1; bus.auxDest = 4'd7; bus.auxResult = 32'hA; step();
      bus.auxResult = 32'hB; step();
      bus.auxValid = 1'b0; bus.src2 = 4'd7;
      #1;
`ifdef REGFILE_ARB_FORWARD_EN
      cmp("fwd_valid2", 64'(bus.fwdValid2), 64'd1);
      cmp("fwd_data2", 64'(bus.fwdData2), 64'hB);
      cmp("fwd_hazard", 64'(bus.hazard), 64'd0);
`else
      cmp("nofwd_valid2", 64'(bus.fwdValid2), 64'd0);
      cmp("nofwd_hazard", 64'(bus.hazard), 64'd1);
`endif
      bus.wbEn = 1'b0; bus.src2 = 4'd0;
      repeat (3) step();

      // mixed traffic: wrap-around, simultaneous push/pop, kills and PC requests
      for (int i = 0; i < 48; i++) begin
         bus.wbEn      = (i % 3 == 1);
         bus.wbDest    = 4'(i % 16);
         bus.wbResult  = 32'(i * 3);
         bus.auxValid  = (i % 4 != 3);
         bus.auxDest   = 4'((i * 7) % 16);
         bus.auxResult = 32'h1000 + 32'(i);
         bus.src1      = 4'((i * 5) % 16);
         bus.src2      = 4'((i + 3) % 16);
         step();
      end
      idle();
      repeat (6) step();
      @(negedge clk);
      #1;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Shares the register file's single write port (writeBackEn/destWB/resultWB) between two requesters.
- Requester 1: the pipeline WB stage, which has fixed priority and is never back-pressured.
- Requester 2: an auxiliary multi-cycle unit (MUL/LDM), which uses a valid/ready handshake and is buffered in a small in-order FIFO.
- Also provides a pending-destination scoreboard for the hazard unit and a starvation stall request.

Parameters:
- DATA_W, 32, register data width
- ADDR_W, 4, register index width; index 15 (PC) is never written through this block
- FIFO_DEPTH, 4, aux pending-write FIFO entries (power of 2, >=2)
- STARVE_LIMIT, 8, consecutive cycles a valid FIFO head may lose before stallReq asserts

Ports:
- clk  in  1  clock; all state updates on posedge
- rst  in  1  synchronous, active-high reset
- wbEn  in  1  pipeline WB write request
- wbDest  in  ADDR_W  pipeline WB destination
- wbResult  in  DATA_W  pipeline WB data
- auxValid  in  1  aux write request
- auxReady  out  1  aux accept; handshake occurs when auxValid&auxReady
- auxDest  in  ADDR_W  aux destination
- auxResult  in  DATA_W  aux data
- writeBackEn  out  1  registered write enable to register file
- destWB  out  ADDR_W  registered write index
- resultWB  out  DATA_W  registered write data
- src1  in  ADDR_W  decode-stage source 1
- src2  in  ADDR_W  decode-stage source 2
- hazard  out  1  a source matches a live pending FIFO entry
- stallReq  out  1  request that the pipeline hold wbEn low
- pendCount  out  log2(FIFO_DEPTH)+1  live + killed entries currently in FIFO

Behaviour:
- Clock and reset: single clock clk; rst is synchronous, active-high.
- Reset values: writeBackEn=0, destWB=0, resultWB=0, FIFO empty, all entry valid bits 0, starve counter 0, stallReq=0, pendCount=0, auxReady=1 on the first cycle after reset.
- Reset mid-operation: rst discards all pending aux entries; no write issues in the reset cycle.
- auxReady = !full, derived from registered state only.
  - When full, no push occurs even if a pop happens in the same cycle.
- Aux handshake with auxDest!=15: pushes {dest, data, live=1} into the FIFO tail. All aux writes go through the FIFO; there is no bypass.
- Aux handshake with auxDest==15: the request is accepted and discarded; nothing is enqueued.
- Grant per cycle, with outputs registered (1-cycle latency):
  - wbEn=1 and wbDest!=15: WB wins. The next cycle shows writeBackEn=1 with wbDest/wbResult.
  - wbEn=1 and wbDest==15: no write is issued, and the FIFO head is not served that cycle.
  - wbEn=0 and FIFO head live: the head is popped and written the next cycle.
  - wbEn=0 and FIFO head killed: the head is popped silently; writeBackEn=0 the next cycle.
  - Otherwise writeBackEn=0. destWB/resultWB hold their last value whenever writeBackEn=0.
- Ordering kill: when a WB write is granted to dest D, every FIFO entry with dest D clears its live bit in the same cycle.
  - WB is program-order younger, because hazard stalls the pipeline behind older aux writes.
- Aux min latency: handshake at cycle N, write visible at N+2 if uncontested.
- hazard is combinational and asserts when src1 or src2 matches the dest of any live FIFO entry.
  - src==15 never matches.
  - An entry pushed this cycle is not yet visible; the aux unit signals its own hazards.
- Starvation:
  - The counter increments each cycle the FIFO head is live and WB wins; it clears on a head pop or when the FIFO is empty.
  - stallReq=1 (registered) once counter>=STARVE_LIMIT, and stays 1 until the head pops.
  - If wbEn stays high during stallReq, WB still wins (pipeline contract violation, no corruption).
- Simultaneous push and pop on a non-full FIFO: both occur, and pendCount is unchanged.
- Pointers wrap modulo FIFO_DEPTH; full/empty are distinguished by an extra pointer bit.

Optional Feature:
- Macro: REGFILE_ARB_FORWARD_EN
- Enabled:
  - Adds outputs fwdValid1, fwdValid2 (1 bit each) and fwdData1, fwdData2 (DATA_W each).
  - Each carries the data of the youngest live FIFO entry matching src1 or src2, respectively.
  - hazard is suppressed for any source that is forwarded.
- Disabled:
  - These ports exist but are tied to 0.
  - hazard behaves exactly as specified above.

Test Plan:
- Reset: assert rst for 2 cycles with auxValid=1 -> writeBackEn=0, pendCount=0, auxReady=1 the cycle after release, nothing enqueued.
- Uncontested aux: push dest 3, data 0xDEAD at cycle N -> writeBackEn=1, destWB=3, resultWB=0xDEAD at N+2; hazard=1 for src1=3 during N+1 only.
- Full FIFO and stall: wbEn=1 continuously and push 4 aux entries -> auxReady=0 after the 4th; stallReq=1 after 8 losing cycles. Then drop wbEn -> entries drain in order over 4 cycles, stallReq clears after the first pop.
- Kill: aux push dest 5=0x11, then WB dest 5=0x22 granted while the entry is pending -> the only write to 5 is 0x22; the killed entry pops with writeBackEn=0; hazard on 5 clears.
- PC dest: wbDest=15 and auxDest=15 -> writeBackEn never 1 for dest 15, pendCount unchanged.
- With REGFILE_ARB_FORWARD_EN: two pending entries to dest 7 (0xA, then 0xB), src2=7 -> fwdValid2=1, fwdData2=0xB, hazard=0.
